// File: rtl/pim_seq_pkg.sv
// pim_seq_pkg: shared types and constants for the PIM conv sequencer
//   state_e     : sequencer FSM states
//   plane_sum() : combines the two weight-plane ADC results of one slice
package pim_seq_pkg;
    localparam int ADDR_W      = 5;
    localparam int ADC_P       = 6;
    localparam int SLICE_W     = 3;
    localparam int OUT_W       = 18;
    localparam int SHIFT_PLANE = 3;
    localparam int SHIFT_SLICE = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_HI,
        WAIT_HI,
        ISSUE_LO,
        WAIT_LO,
        OUTPUT
    } state_e;

    function automatic logic [OUT_W-1:0] plane_sum(input logic [ADC_P-1:0] h, input logic [ADC_P-1:0] l);
        return (OUT_W'(h) << SHIFT_PLANE) + OUT_W'(l);
    endfunction
endpackage

// File: rtl/pim_conv_sequencer_if.sv
// pim_conv_sequencer_if: job, crossbar/ADC and result buses of the conv sequencer
//   job_*  : job offer from the layer scheduler (valid/ready)
//   pim_*  : crossbar compute strobe, address and input slice
//   adc_*  : weight-high / weight-low plane ADC results
//   out_*  : result stream to the consumer (valid/ready), busy flag
//   master : sequencer side, slave : environment side
interface pim_conv_sequencer_if;
    import pim_seq_pkg::*;
    logic                 job_valid;
    logic                 job_ready;
    logic [2*SLICE_W-1:0] job_data;
    logic [ADDR_W-1:0]    job_first_addr;
    logic [ADDR_W:0]      job_num_addr;
    logic                 pim_en;
    logic [ADDR_W-1:0]    pim_addr;
    logic [SLICE_W-1:0]   pim_feature;
    logic [ADC_P-1:0]     adc_h;
    logic [ADC_P-1:0]     adc_l;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic [ADDR_W-1:0]    out_addr;
    logic                 out_last;
    logic                 busy;

    modport master (
        input  job_valid, job_data, job_first_addr, job_num_addr, adc_h, adc_l, out_ready,
        output job_ready, pim_en, pim_addr, pim_feature, out_valid, out_data, out_addr, out_last, busy
    );

    modport slave (
        output job_valid, job_data, job_first_addr, job_num_addr, adc_h, adc_l, out_ready,
        input  job_ready, pim_en, pim_addr, pim_feature, out_valid, out_data, out_addr, out_last, busy
    );
endinterface

// File: rtl/pim_slice_accum.sv
// pim_slice_accum: clear/add-shifted accumulator for the two input slices
//   clr      : zero the sum (start of an address)
//   add_en   : add the plane-combined ADC term this cycle
//   slice_hi : term belongs to the high input slice, shift it up one slice
//   sum      : accumulated result
module pim_slice_accum
    import pim_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add_en,
    input  logic             slice_hi,
    input  logic [ADC_P-1:0] adc_h,
    input  logic [ADC_P-1:0] adc_l,
    output logic [OUT_W-1:0] sum
);
    logic [OUT_W-1:0] acc_q, acc_d, term;

    always_comb begin
        term  = slice_hi ? plane_sum(adc_h, adc_l) << SHIFT_SLICE : plane_sum(adc_h, adc_l);
        acc_d = clr ? '0 : add_en ? acc_q + term : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;

    assign sum = acc_q;
endmodule

// File: rtl/pim_conv_sequencer.sv
// pim_conv_sequencer: job-level controller for one bit-sliced PIM conv crossbar
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : job input, crossbar issue, ADC return and result stream
//   Per address: issue high slice, wait ADC_LAT, issue low slice, wait
//   ADC_LAT, then present the shift-added result until accepted.
module pim_conv_sequencer
    import pim_seq_pkg::*;
#(
    parameter int ADC_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    pim_conv_sequencer_if.master bus
);
    localparam int WCW = (ADC_LAT > 1) ? $clog2(ADC_LAT) : 1;
    localparam int DW  = 2 * SLICE_W;

    state_e             state_q, state_d;
    logic [DW-1:0]      data_q, data_d;
    logic [ADDR_W-1:0]  first_q, first_d, pim_addr_q, pim_addr_d;
    logic [ADDR_W:0]    count_q, count_d, idx_q, idx_d;
    logic [WCW-1:0]     wcnt_q, wcnt_d;
    logic [SLICE_W-1:0] pim_feat_q, pim_feat_d;
    logic               accept, waiting, wait_done, issue, last, fire;
    logic [OUT_W-1:0]   acc;

    assign accept    = (state_q == IDLE) && bus.job_valid;
    assign waiting   = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    // ADC results are valid in the ADC_LAT-th cycle after the issue cycle
    assign wait_done = waiting && (wcnt_q == WCW'(ADC_LAT - 1));
    assign issue     = (state_q == ISSUE_HI) || (state_q == ISSUE_LO);
    assign last      = (idx_q + (ADDR_W+1)'(1)) == count_q;
    assign fire      = (state_q == OUTPUT) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && bus.job_num_addr != '0) state_d = ISSUE_HI;
            ISSUE_HI: state_d = WAIT_HI;
            WAIT_HI:  if (wait_done) state_d = ISSUE_LO;
            ISSUE_LO: state_d = WAIT_LO;
            WAIT_LO:  if (wait_done) state_d = OUTPUT;
            OUTPUT:   if (fire) state_d = last ? IDLE : ISSUE_HI;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d     = accept ? bus.job_data : data_q;
        first_d    = accept ? bus.job_first_addr : first_q;
        count_d    = accept ? bus.job_num_addr : count_q;
        idx_d      = accept ? '0 : fire ? idx_q + (ADDR_W+1)'(1) : idx_q;
        wcnt_d     = (waiting && !wait_done) ? wcnt_q + WCW'(1) : '0;
        // address wraps modulo 2^ADDR_W; crossbar bus holds between issues
        pim_addr_d = issue ? first_q + idx_q[ADDR_W-1:0] : pim_addr_q;
        pim_feat_d = (state_q == ISSUE_HI) ? data_q[DW-1:SLICE_W] :
                     (state_q == ISSUE_LO) ? data_q[SLICE_W-1:0] : pim_feat_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            data_q     <= '0;
            first_q    <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            wcnt_q     <= '0;
            pim_addr_q <= '0;
            pim_feat_q <= '0;
        end else begin
            data_q     <= data_d;
            first_q    <= first_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            wcnt_q     <= wcnt_d;
            pim_addr_q <= pim_addr_d;
            pim_feat_q <= pim_feat_d;
        end

    pim_slice_accum u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_q == ISSUE_HI),
        .add_en   (wait_done),
        .slice_hi (state_q == WAIT_HI),
        .adc_h    (bus.adc_h),
        .adc_l    (bus.adc_l),
        .sum      (acc)
    );

    always_comb begin
        bus.job_ready   = state_q == IDLE;
        bus.busy        = state_q != IDLE;
        bus.pim_en      = issue;
        bus.pim_addr    = pim_addr_d;
        bus.pim_feature = pim_feat_d;
        bus.out_valid   = state_q == OUTPUT;
        bus.out_data    = acc;
        bus.out_addr    = first_q + idx_q[ADDR_W-1:0];
        bus.out_last    = (state_q == OUTPUT) && last;
    end
endmodule

// File: tb/tb_pim_conv_sequencer.sv
// tb_pim_conv_sequencer: directed bench for pim_conv_sequencer with an ADC model
//   ADC model: adc_h = 2*feature, adc_l = feature, valid exactly ADC_LAT
//   cycles after pim_en (junk otherwise), or 63/63 in max mode.
module tb_pim_conv_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    bit   max_mode;
    int   vectors;
    int   errors;
    logic [2:0] f1, f2;
    logic v1, v2;

    pim_conv_sequencer_if bus();

    pim_conv_sequencer #(.ADC_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        v1 <= bus.pim_en;
        f1 <= bus.pim_feature;
        v2 <= v1;
        f2 <= f1;
    end

    assign bus.adc_h = v2 ? (max_mode ? 6'd63 : {2'b00, f2, 1'b0}) : 6'd17;
    assign bus.adc_l = v2 ? (max_mode ? 6'd63 : {3'b000, f2}) : 6'd9;

    task automatic send_job(input logic [5:0] d, input logic [4:0] first, input logic [5:0] num);
        bus.job_valid      = 1'b1;
        bus.job_data       = d;
        bus.job_first_addr = first;
        bus.job_num_addr   = num;
        @(negedge clk);
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            @(negedge clk);
            n++;
            ok = bus.out_valid;
        end
    endtask

    task automatic test_reset;
        vectors++; if (bus.job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready got %b exp 1", bus.job_ready); end
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        vectors++; if ({bus.pim_en, bus.pim_addr, bus.pim_feature} !== 9'd0) begin errors++; $display("FAIL reset_pim got %b/%0d/%0d exp 0/0/0", bus.pim_en, bus.pim_addr, bus.pim_feature); end
        vectors++; if ({bus.out_valid, bus.out_data, bus.out_addr, bus.out_last} !== 25'd0) begin errors++; $display("FAIL reset_out got %b/%0d/%0d/%b exp 0", bus.out_valid, bus.out_data, bus.out_addr, bus.out_last); end
    endtask

    task automatic test_single;
        send_job(6'b101011, 5'd3, 6'd1);
        vectors++; if ({bus.pim_en, bus.pim_feature, bus.pim_addr} !== {1'b1, 3'd5, 5'd3}) begin errors++; $display("FAIL single_issue_hi got en=%b f=%0d a=%0d exp 1/5/3", bus.pim_en, bus.pim_feature, bus.pim_addr); end
        vectors++; if ({bus.job_ready, bus.busy} !== 2'b01) begin errors++; $display("FAIL single_busy got rdy=%b busy=%b exp 0/1", bus.job_ready, bus.busy); end
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            vectors++; if (bus.pim_en !== (k == 4)) begin errors++; $display("FAIL single_pim_en k=%0d got %b exp %b", k, bus.pim_en, k == 4); end
            vectors++; if (bus.out_valid !== (k == 7)) begin errors++; $display("FAIL single_out_valid k=%0d got %b exp %b", k, bus.out_valid, k == 7); end
            if (k == 2) begin
                vectors++; if ({bus.pim_feature, bus.pim_addr} !== {3'd5, 5'd3}) begin errors++; $display("FAIL single_hold got f=%0d a=%0d exp 5/3", bus.pim_feature, bus.pim_addr); end
            end
            if (k == 4) begin
                vectors++; if ({bus.pim_feature, bus.pim_addr} !== {3'd3, 5'd3}) begin errors++; $display("FAIL single_issue_lo got f=%0d a=%0d exp 3/3", bus.pim_feature, bus.pim_addr); end
            end
            if (k == 7) begin
                vectors++; if (bus.out_data !== 18'd731) begin errors++; $display("FAIL single_data got %0d exp 731", bus.out_data); end
                vectors++; if ({bus.out_addr, bus.out_last} !== {5'd3, 1'b1}) begin errors++; $display("FAIL single_addr_last got %0d/%b exp 3/1", bus.out_addr, bus.out_last); end
            end
            if (k == 8) begin
                vectors++; if (bus.job_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after got %b exp 1", bus.job_ready); end
            end
        end
    endtask

    task automatic test_wrap;
        logic [4:0] exp_addr [3] = '{5'd31, 5'd0, 5'd1};
        bit ok;
        send_job(6'd22, 5'd31, 6'd3);
        for (int i = 0; i < 3; i++) begin
            wait_valid(ok);
            vectors++; if (!ok) begin errors++; $display("FAIL wrap_timeout i=%0d got no out_valid exp out_valid", i); end
            vectors++; if (bus.out_addr !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr i=%0d got %0d exp %0d", i, bus.out_addr, exp_addr[i]); end
            vectors++; if (bus.out_last !== (i == 2)) begin errors++; $display("FAIL wrap_last i=%0d got %b exp %b", i, bus.out_last, i == 2); end
            vectors++; if (bus.out_data !== 18'd374) begin errors++; $display("FAIL wrap_data i=%0d got %0d exp 374", i, bus.out_data); end
        end
        @(negedge clk);
        vectors++; if (bus.job_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_after got %b exp 1", bus.job_ready); end
    endtask

    task automatic test_backpressure;
        bit ok;
        bus.out_ready = 1'b0;
        send_job(6'd45, 5'd5, 6'd2);
        wait_valid(ok);
        vectors++; if (!ok) begin errors++; $display("FAIL bp_timeout got no out_valid exp out_valid"); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++; if ({bus.out_valid, bus.out_data, bus.out_addr, bus.out_last, bus.pim_en} !== {1'b1, 18'd765, 5'd5, 1'b0, 1'b0}) begin
                errors++; $display("FAIL bp_stall k=%0d got v=%b d=%0d a=%0d l=%b en=%b exp 1/765/5/0/0", k, bus.out_valid, bus.out_data, bus.out_addr, bus.out_last, bus.pim_en);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        vectors++; if ({bus.pim_en, bus.pim_addr} !== {1'b1, 5'd6}) begin errors++; $display("FAIL bp_resume got en=%b a=%0d exp 1/6", bus.pim_en, bus.pim_addr); end
        wait_valid(ok);
        vectors++; if ({ok, bus.out_data, bus.out_addr, bus.out_last} !== {1'b1, 18'd765, 5'd6, 1'b1}) begin
            errors++; $display("FAIL bp_second got ok=%b d=%0d a=%0d l=%b exp 1/765/6/1", ok, bus.out_data, bus.out_addr, bus.out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_count;
        send_job(6'd9, 5'd4, 6'd0);
        vectors++; if ({bus.job_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL zero_ready got rdy=%b busy=%b exp 1/0", bus.job_ready, bus.busy); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++; if ({bus.pim_en, bus.out_valid, bus.job_ready} !== 3'b001) begin
                errors++; $display("FAIL zero_idle k=%0d got en=%b v=%b rdy=%b exp 0/0/1", k, bus.pim_en, bus.out_valid, bus.job_ready);
            end
        end
    endtask

    task automatic test_max;
        bit ok;
        max_mode = 1'b1;
        send_job(6'd63, 5'd0, 6'd1);
        wait_valid(ok);
        vectors++; if ({ok, bus.out_data} !== {1'b1, 18'd5103}) begin errors++; $display("FAIL max_data got ok=%b d=%0d exp 1/5103", ok, bus.out_data); end
        @(negedge clk);
        max_mode = 1'b0;
    endtask

    task automatic test_reset_midjob;
        bit ok;
        send_job(6'd20, 5'd7, 6'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if ({bus.pim_en, bus.pim_addr, bus.pim_feature, bus.busy} !== 10'd0) begin
            errors++; $display("FAIL midrst_pim got en=%b a=%0d f=%0d busy=%b exp 0", bus.pim_en, bus.pim_addr, bus.pim_feature, bus.busy);
        end
        vectors++; if ({bus.out_valid, bus.out_data, bus.out_addr, bus.out_last} !== 25'd0) begin
            errors++; $display("FAIL midrst_out got v=%b d=%0d a=%0d l=%b exp 0", bus.out_valid, bus.out_data, bus.out_addr, bus.out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.job_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", bus.job_ready); end
        send_job(6'd11, 5'd2, 6'd1);
        wait_valid(ok);
        vectors++; if ({ok, bus.out_data, bus.out_addr, bus.out_last} !== {1'b1, 18'd187, 5'd2, 1'b1}) begin
            errors++; $display("FAIL midrst_newjob got ok=%b d=%0d a=%0d l=%b exp 1/187/2/1", ok, bus.out_data, bus.out_addr, bus.out_last);
        end
        @(negedge clk);
    endtask

    initial begin
        vectors            = 0;
        errors             = 0;
        max_mode           = 1'b0;
        rst_n              = 1'b0;
        bus.job_valid      = 1'b0;
        bus.job_data       = '0;
        bus.job_first_addr = '0;
        bus.job_num_addr   = '0;
        bus.out_ready      = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_single();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_max();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
